// File: rtl/note_sequencer_if.sv
// ---------------------------------------------------------------------------
// note_sequencer_if
//   Bundles the signals that pass between the note sequencer, its host and
//   the 128-entry note recorder.
//
//   Host command side : cmd_valid, cmd_ready, cmd_op, cmd_note, cmd_start,
//                       cmd_len, tempo, abort, busy
//   Recorder side     : rec_op, rec_note, rec_query (sequencer drives),
//                       rec_note_out, rec_count (recorder returns)
//   Result side       : play_valid, play_note, play_idx, play_done,
//                       cnt_valid, cnt_value
//
//   modport slave  : the sequencer's view
//   modport master : the environment's view (host plus recorder)
// ---------------------------------------------------------------------------
interface note_sequencer_if #(
   parameter int TEMPO_W = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [2:0]         cmd_note;
   logic [6:0]         cmd_start;
   logic [7:0]         cmd_len;
   logic [TEMPO_W-1:0] tempo;
   logic               abort;
   logic               busy;

   logic [1:0]         rec_op;
   logic [2:0]         rec_note;
   logic [6:0]         rec_query;
   logic [2:0]         rec_note_out;
   logic [7:0]         rec_count;

   logic               play_valid;
   logic [2:0]         play_note;
   logic [6:0]         play_idx;
   logic               play_done;
   logic               cnt_valid;
   logic [7:0]         cnt_value;

   modport slave (
      input  cmd_valid, cmd_op, cmd_note, cmd_start, cmd_len, tempo, abort,
      input  rec_note_out, rec_count,
      output cmd_ready, busy, rec_op, rec_note, rec_query,
      output play_valid, play_note, play_idx, play_done, cnt_valid, cnt_value
   );

   modport master (
      output cmd_valid, cmd_op, cmd_note, cmd_start, cmd_len, tempo, abort,
      output rec_note_out, rec_count,
      input  cmd_ready, busy, rec_op, rec_note, rec_query,
      input  play_valid, play_note, play_idx, play_done, cnt_valid, cnt_value
   );
endinterface

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//   Host-facing controller for a 128-entry note recorder. Accepts one command
//   at a time while idle:
//     cmd_op 00 record : one recorder write of cmd_note
//     cmd_op 01 play   : read cmd_len notes starting at cmd_start, emitting a
//                        one-cycle play_valid strobe per note, with
//                        max(tempo,1) wait cycles between notes
//     cmd_op 10 count  : ask the recorder how many entries hold cmd_note
//     cmd_op 11        : endless loop-play when NOTE_SEQ_LOOP_EN is defined,
//                        otherwise accepted and dropped
//   abort ends a play/loop-play through DONE (one-cycle play_done).
//
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : note_sequencer_if.slave (command, recorder and result signals)
//
//   Build option: define NOTE_SEQ_LOOP_EN to enable loop-play on cmd_op 11.
//
//   Recorder op encoding: 00 write, 01 read, 10 hold, 11 count.
// ---------------------------------------------------------------------------
module note_sequencer #(
   parameter int TEMPO_W = 8
) (
   input logic               clk,
   input logic               reset,
   note_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REC,
      S_PLAY_RD,
      S_PLAY_CAP,
      S_PLAY_WAIT,
      S_CNT_ISSUE,
      S_CNT_CAP,
      S_DONE
   } state_t;

   localparam logic [1:0] CMD_REC   = 2'b00;
   localparam logic [1:0] CMD_PLAY  = 2'b01;
   localparam logic [1:0] CMD_COUNT = 2'b10;
   localparam logic [1:0] CMD_LOOP  = 2'b11;

   localparam logic [1:0] REC_WRITE = 2'b00;
   localparam logic [1:0] REC_READ  = 2'b01;
   localparam logic [1:0] REC_HOLD  = 2'b10;
   localparam logic [1:0] REC_COUNT = 2'b11;

   localparam logic [TEMPO_W-1:0] WAIT_ONE = TEMPO_W'(1);

   state_t             state;
   logic [6:0]         idx_q;     // buffer index of the note being fetched
   logic [7:0]         remain_q;  // strobes still owed for a bounded play
   logic [TEMPO_W-1:0] tempo_q;   // max(tempo,1), latched at acceptance
   logic [TEMPO_W-1:0] wait_q;    // cycles left in PLAY_WAIT
   logic               loop_q;    // current play ignores cmd_len

   assign bus.cmd_ready = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);

   // NOTE: all state here is sequential, so every assignment is non-blocking;
   // a blocking assignment would let later statements see the new value
   // within the same edge and break the register timing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         idx_q          <= '0;
         remain_q       <= '0;
         tempo_q        <= WAIT_ONE;
         wait_q         <= WAIT_ONE;
         loop_q         <= 1'b0;
         bus.rec_op     <= REC_HOLD;
         bus.rec_note   <= '0;
         bus.rec_query  <= '0;
         bus.play_valid <= 1'b0;
         bus.play_note  <= '0;
         bus.play_idx   <= '0;
         bus.play_done  <= 1'b0;
         bus.cnt_valid  <= 1'b0;
         bus.cnt_value  <= '0;
      end else begin
         // NOTE: pulses and the recorder op fall back to their idle values
         // every edge; the state cases below only override when active.
         bus.play_valid <= 1'b0;
         bus.play_done  <= 1'b0;
         bus.cnt_valid  <= 1'b0;
         bus.rec_op     <= REC_HOLD;

         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  case (bus.cmd_op)
                     CMD_REC: begin
                        bus.rec_op   <= REC_WRITE;
                        bus.rec_note <= bus.cmd_note;
                        state        <= S_REC;
                     end
                     CMD_PLAY: begin
                        loop_q   <= 1'b0;
                        idx_q    <= bus.cmd_start;
                        remain_q <= bus.cmd_len;
                        tempo_q  <= (bus.tempo == '0) ? WAIT_ONE : bus.tempo;
                        if (bus.cmd_len == 8'd0) begin
                           bus.play_done <= 1'b1;
                           state         <= S_DONE;
                        end else begin
                           bus.rec_op    <= REC_READ;
                           bus.rec_query <= bus.cmd_start;
                           state         <= S_PLAY_RD;
                        end
                     end
                     CMD_COUNT: begin
                        bus.rec_op    <= REC_COUNT;
                        bus.rec_query <= {4'b0000, bus.cmd_note};
                        state         <= S_CNT_ISSUE;
                     end
                     CMD_LOOP: begin
`ifdef NOTE_SEQ_LOOP_EN
                        loop_q        <= 1'b1;
                        idx_q         <= bus.cmd_start;
                        tempo_q       <= (bus.tempo == '0) ? WAIT_ONE : bus.tempo;
                        bus.rec_op    <= REC_READ;
                        bus.rec_query <= bus.cmd_start;
                        state         <= S_PLAY_RD;
`else
                        // Accepted and dropped: stay idle, recorder untouched.
                        loop_q <= 1'b0;
`endif
                     end
                  endcase
               end
            end

            S_REC: state <= S_IDLE;

            S_PLAY_RD: begin
               if (bus.abort) begin
                  bus.play_done <= 1'b1;
                  state         <= S_DONE;
               end else begin
                  state <= S_PLAY_CAP;
               end
            end

            S_PLAY_CAP: begin
               if (bus.abort) begin
                  bus.play_done <= 1'b1;
                  state         <= S_DONE;
               end else begin
                  bus.play_valid <= 1'b1;
                  bus.play_note  <= bus.rec_note_out;
                  bus.play_idx   <= idx_q;
                  if (!loop_q) remain_q <= remain_q - 8'd1;
                  // After the final strobe wait a single cycle so play_done
                  // lands directly behind it instead of a full tempo later.
                  wait_q <= (!loop_q && remain_q == 8'd1) ? WAIT_ONE : tempo_q;
                  state  <= S_PLAY_WAIT;
               end
            end

            S_PLAY_WAIT: begin
               if (bus.abort) begin
                  bus.play_done <= 1'b1;
                  state         <= S_DONE;
               end else if (wait_q == WAIT_ONE) begin
                  if (!loop_q && remain_q == 8'd0) begin
                     bus.play_done <= 1'b1;
                     state         <= S_DONE;
                  end else begin
                     // 7-bit index rolls 127 -> 0 on its own.
                     idx_q         <= idx_q + 7'd1;
                     bus.rec_op    <= REC_READ;
                     bus.rec_query <= idx_q + 7'd1;
                     state         <= S_PLAY_RD;
                  end
               end else begin
                  wait_q <= wait_q - WAIT_ONE;
               end
            end

            S_CNT_ISSUE: state <= S_CNT_CAP;

            S_CNT_CAP: begin
               bus.cnt_value <= bus.rec_count;
               bus.cnt_valid <= 1'b1;
               state         <= S_IDLE;
            end

            S_DONE: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
//   Directed bench for note_sequencer. A behavioural recorder (shift-in
//   buffer, newest note at index 127) answers read and count requests one
//   edge after they are issued. Expected strobes, counts and done pulses are
//   queued by the stimulus; a negedge monitor pops and compares them.
//   Define NOTE_SEQ_LOOP_EN for both the bench and the RTL to cover
//   loop-play.
// ---------------------------------------------------------------------------
module tb_note_sequencer;

   localparam int TEMPO_W = 8;

   logic clk;
   logic reset;
   int   cyc;
   int   tests;
   int   fails;
   int   accept_cyc;
   int   last_strobe;

   note_sequencer_if #(.TEMPO_W(TEMPO_W)) bus ();

   note_sequencer #(.TEMPO_W(TEMPO_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- recorder model ----------------
   logic [2:0] mem [128] = '{default: 3'd0};

   always @(posedge clk) begin
      int unsigned c;
      c = 0;
      case (bus.rec_op)
         2'b00: begin
            for (int i = 0; i < 127; i++) mem[i] <= mem[i+1];
            mem[127] <= bus.rec_note;
         end
         2'b01: bus.rec_note_out <= mem[bus.rec_query];
         2'b11: begin
            for (int i = 0; i < 128; i++)
               if (mem[i] == bus.rec_query[2:0]) c++;
            bus.rec_count <= 8'(c);
         end
         default: ;
      endcase
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [2:0] note;
      logic [6:0] idx;
      int         gap;   // 0: first strobe (2 cycles after accept)
   } play_exp_t;

   typedef struct {
      logic [7:0] value;
      int         at_cyc;
   } cnt_exp_t;

   play_exp_t play_q [$];
   cnt_exp_t  cnt_q  [$];
   int        done_q [$];   // cycles after last strobe, -1 = don't care

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      play_exp_t pe;
      cnt_exp_t  ce;
      int        dg;
      if (bus.play_valid) begin
         check("strobe_expected", play_q.size() != 0, 1);
         if (play_q.size() != 0) begin
            pe = play_q.pop_front();
            check("play_note", bus.play_note, pe.note);
            check("play_idx", bus.play_idx, pe.idx);
            if (pe.gap == 0) check("first_strobe_latency", cyc - accept_cyc, 2);
            else             check("strobe_spacing", cyc - last_strobe, pe.gap);
         end
         last_strobe = cyc;
      end
      if (bus.cnt_valid) begin
         check("cnt_expected", cnt_q.size() != 0, 1);
         if (cnt_q.size() != 0) begin
            ce = cnt_q.pop_front();
            check("cnt_value", bus.cnt_value, ce.value);
            check("cnt_timing", cyc, ce.at_cyc);
         end
      end
      if (bus.play_done) begin
         check("done_expected", done_q.size() != 0, 1);
         if (done_q.size() != 0) begin
            dg = done_q.pop_front();
            if (dg >= 0) check("done_after_last_strobe", cyc - last_strobe, dg);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(input logic [1:0] op, input logic [2:0] note,
                           input logic [6:0] start, input logic [7:0] len,
                           input logic [7:0] tmp, output int e);
      int n;
      @(negedge clk);
      bus.cmd_op    = op;
      bus.cmd_note  = note;
      bus.cmd_start = start;
      bus.cmd_len   = len;
      bus.tempo     = tmp;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("cmd_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      e = cyc;
      accept_cyc = cyc;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check("idle_timeout", 0, 1);
   endtask

   task automatic wait_strobes(input int count, input int budget);
      int seen;
      int n;
      seen = 0;
      n = 0;
      while (seen < count && n < budget) begin
         @(negedge clk);
         if (bus.play_valid) seen++;
         n++;
      end
      if (seen < count) check("strobe_wait_timeout", seen, count);
   endtask

   // Buffer contents after the records 1,2,3,4,5,2,2 (newest at 127).
   function automatic logic [2:0] exp_note(input logic [6:0] idx);
      case (idx)
         7'd121:  return 3'd1;
         7'd122:  return 3'd2;
         7'd123:  return 3'd3;
         7'd124:  return 3'd4;
         7'd125:  return 3'd5;
         7'd126:  return 3'd2;
         7'd127:  return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   task automatic record(input logic [2:0] n);
      int e;
      send_cmd(2'b00, n, 7'd0, 8'd0, 8'd0, e);
      check("rec_op_write", bus.rec_op, 2'b00);
      check("rec_note", bus.rec_note, n);
      check("rec_ready_low", bus.cmd_ready, 0);
      @(posedge clk);
      #1;
      check("rec_op_hold_after", bus.rec_op, 2'b10);
      check("rec_ready_back", bus.cmd_ready, 1);
   endtask

   task automatic check_reset_values();
      check("rst_rec_op", bus.rec_op, 2'b10);
      check("rst_rec_note", bus.rec_note, 0);
      check("rst_rec_query", bus.rec_query, 0);
      check("rst_play_valid", bus.play_valid, 0);
      check("rst_play_note", bus.play_note, 0);
      check("rst_play_idx", bus.play_idx, 0);
      check("rst_play_done", bus.play_done, 0);
      check("rst_cnt_valid", bus.cnt_valid, 0);
      check("rst_cnt_value", bus.cnt_value, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int e;
      // NOTE: bench drives inputs with blocking assignments away from the
      // active edge so the DUT samples settled values.
      cyc = 0; tests = 0; fails = 0; accept_cyc = 0; last_strobe = 0;
      reset = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_note = 3'd0;
      bus.cmd_start = 7'd0; bus.cmd_len = 8'd0; bus.tempo = 8'd0;
      bus.abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      @(negedge clk);
      reset = 1'b1;

      // Record 1..5: buffer 123..127 = 1..5.
      for (int n = 1; n <= 5; n++) record(3'(n));

      // Play 123, len 5, tempo 0: strobes 3 cycles apart.
      for (int k = 0; k < 5; k++)
         play_q.push_back('{note: 3'(k + 1), idx: 7'(123 + k), gap: (k == 0) ? 0 : 3});
      done_q.push_back(1);
      send_cmd(2'b01, 3'd0, 7'd123, 8'd5, 8'd0, e);
      wait_idle(100);

      // Play 126, len 3, tempo 4: wraps to 0, strobes 6 apart; host
      // record attempts during play must be ignored.
      play_q.push_back('{note: 3'd4, idx: 7'd126, gap: 0});
      play_q.push_back('{note: 3'd5, idx: 7'd127, gap: 6});
      play_q.push_back('{note: 3'd0, idx: 7'd0,   gap: 6});
      done_q.push_back(1);
      send_cmd(2'b01, 3'd0, 7'd126, 8'd3, 8'd4, e);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.cmd_op = 2'b00; bus.cmd_note = 3'd7; bus.cmd_valid = 1'b1;
         @(posedge clk);
         #1;
         check("busy_cmd_ignored", bus.rec_op != 2'b00, 1);
      end
      bus.cmd_valid = 1'b0;
      wait_idle(100);

      // Two more 2s: buffer 121..127 = 1,2,3,4,5,2,2.
      record(3'd2);
      record(3'd2);

      // Count 7 (never recorded; the ignored host writes must not count).
      send_cmd(2'b10, 3'd7, 7'd0, 8'd0, 8'd0, e);
      cnt_q.push_back('{value: 8'd0, at_cyc: e + 2});
      wait_idle(20);
      // Count 0: 121 empty slots.
      send_cmd(2'b10, 3'd0, 7'd0, 8'd0, 8'd0, e);
      cnt_q.push_back('{value: 8'd121, at_cyc: e + 2});
      wait_idle(20);
      // Count 2: three copies, query held for two cycles.
      send_cmd(2'b10, 3'd2, 7'd0, 8'd0, 8'd0, e);
      cnt_q.push_back('{value: 8'd3, at_cyc: e + 2});
      check("cnt_rec_op", bus.rec_op, 2'b11);
      check("cnt_query_1", bus.rec_query, 2);
      @(posedge clk);
      #1;
      check("cnt_query_2", bus.rec_query, 2);
      check("cnt_rec_op_hold", bus.rec_op, 2'b10);
      wait_idle(20);

      // Abort after second strobe of a len 10 play.
      play_q.push_back('{note: 3'd1, idx: 7'd121, gap: 0});
      play_q.push_back('{note: 3'd2, idx: 7'd122, gap: 4});
      done_q.push_back(1);
      send_cmd(2'b01, 3'd0, 7'd121, 8'd10, 8'd2, e);
      wait_strobes(2, 50);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      @(negedge clk);
      check("ready_after_abort", bus.cmd_ready, 1);
      repeat (20) @(negedge clk);

      // cmd_len = 0: straight to DONE, no strobe.
      done_q.push_back(-1);
      send_cmd(2'b01, 3'd0, 7'd5, 8'd0, 8'd3, e);
      check("len0_done", bus.play_done, 1);
      check("len0_busy", bus.busy, 1);
      wait_idle(20);

`ifdef NOTE_SEQ_LOOP_EN
      // Loop-play from 0 runs past a full buffer lap until abort.
      for (int k = 0; k < 130; k++)
         play_q.push_back('{note: exp_note(7'(k)), idx: 7'(k), gap: (k == 0) ? 0 : 3});
      done_q.push_back(1);
      send_cmd(2'b11, 3'd0, 7'd0, 8'd0, 8'd0, e);
      wait_strobes(130, 1000);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      wait_idle(20);
`else
      // cmd_op 11 without loop support: accepted, no effect.
      send_cmd(2'b11, 3'd3, 7'd0, 8'd4, 8'd0, e);
      check("op11_idle", bus.cmd_ready, 1);
      check("op11_no_rec_op", bus.rec_op, 2'b10);
      repeat (5) @(negedge clk);
`endif

      // Reset mid-play: outputs return to reset values at once, no done.
      play_q.push_back('{note: exp_note(7'd125), idx: 7'd125, gap: 0});
      send_cmd(2'b01, 3'd0, 7'd125, 8'd10, 8'd3, e);
      wait_strobes(1, 20);
      #2;
      reset = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      // First command taken on the first edge after release.
      bus.cmd_op = 2'b10; bus.cmd_note = 3'd2; bus.cmd_valid = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      e = cyc;
      cnt_q.push_back('{value: 8'd3, at_cyc: e + 2});
      check("post_reset_accept", bus.cmd_ready, 0);
      check("post_reset_rec_op", bus.rec_op, 2'b11);
      wait_idle(20);
      repeat (5) @(negedge clk);

      check("play_queue_drained", play_q.size(), 0);
      check("cnt_queue_drained", cnt_q.size(), 0);
      check("done_queue_drained", done_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter: TEMPO_W, 8, width of the tempo input (cycles between playback notes).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 cmd_valid  input  1  host command request.
REQ-005 cmd_ready  output  1  high exactly when the FSM is in IDLE.
REQ-006 cmd_op  input  2  00 record, 01 play, 10 count, 11 loop-play or no-op (see Configuration).
REQ-007 cmd_note  input  3  note to record / note value to count.
REQ-008 cmd_start  input  7  first buffer index for play.
REQ-009 cmd_len  input  8  number of notes to play.
REQ-010 tempo  input  TEMPO_W  inter-note wait for play, sampled at acceptance.
REQ-011 abort  input  1  stops an active play or loop-play.
REQ-012 rec_op, rec_note, rec_query  output  2/3/7  registered drive of the 128-entry note recorder's op, note_in and query ports.
REQ-013 rec_note_out, rec_count  input  3/8  recorder note_out and count.
REQ-014 play_valid, play_note, play_idx  output  1/3/7  one-cycle playback strobe, note, source index.
REQ-015 play_done  output  1  one-cycle pulse when play ends or is aborted.
REQ-016 cnt_valid, cnt_value  output  1/8  one-cycle count strobe and result.
REQ-017 busy  output  1  inverse of cmd_ready.

Function
REQ-018 A command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1; otherwise cmd_* are ignored and not queued.
REQ-019 States: IDLE, REC, PLAY_RD, PLAY_CAP, PLAY_WAIT, CNT_ISSUE, CNT_CAP, DONE.
REQ-020 Outside REC/PLAY_RD/CNT_ISSUE, rec_op shall be 2'b10 (recorder hold).
REQ-021 Record accepted at edge E: rec_op=00, rec_note=cmd_note during cycle E..E+1 (REC); IDLE at E+1.
REQ-022 Play accepted at edge E: PLAY_RD drives rec_op=01, rec_query=current index; PLAY_CAP next cycle; at following edge capture rec_note_out into play_note, play_idx=index, play_valid=1 for one cycle, enter PLAY_WAIT.
REQ-023 First play_valid is high in cycle E+2..E+3; successive strobes exactly 2+max(tempo,1) cycles apart.
REQ-024 PLAY_WAIT lasts max(tempo,1) cycles, then PLAY_RD with index+1 mod 128 (127 wraps to 0).
REQ-025 After cmd_len strobes, enter DONE (play_done=1, one cycle), then IDLE; cmd_len=0 goes directly to DONE with no strobe.
REQ-026 abort=1 in any PLAY_* state: next edge enters DONE; no further play_valid; a strobe already high completes its cycle.
REQ-027 Count accepted at edge E: CNT_ISSUE drives rec_op=11, rec_query={4'b0,cmd_note} for cycle E..E+1; CNT_CAP holds rec_query; at E+2 cnt_value=rec_count, cnt_valid=1 for one cycle; IDLE.
REQ-028 abort in IDLE, REC or CNT_* states has no effect.

Reset
REQ-029 reset=0 asynchronously forces IDLE, rec_op=2'b10, rec_note=0, rec_query=0, play_valid=0, play_note=0, play_idx=0, play_done=0, cnt_valid=0, cnt_value=0, busy=0, cmd_ready=1, including mid-command; no play_done is generated.
REQ-030 First command is accepted on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro NOTE_SEQ_LOOP_EN defined: cmd_op=11 plays as REQ-022..024 but ignores cmd_len and repeats indefinitely until abort, then DONE.
REQ-032 Macro NOTE_SEQ_LOOP_EN undefined: cmd_op=11 is accepted and ignored (IDLE next cycle, no recorder op, no strobes).

Verification
REQ-033 Reset, record notes 1..5 -> rec_op=00 for exactly one cycle per accept with rec_note matching; cmd_ready low that cycle.
REQ-034 After REQ-033 records, play start=123,len=5,tempo=0 -> play_note 1,2,3,4,5 at play_idx 123..127, strobes 3 cycles apart, play_done one cycle after last.
REQ-035 Play start=126,len=3,tempo=4 -> play_idx 126,127,0; strobes 6 cycles apart; cmd_valid pulses during play not accepted.
REQ-036 Recorder holding 3 copies of note 2, count cmd_note=2 -> rec_query=2 for two cycles, cnt_valid at E+2 with cnt_value=3.
REQ-037 Abort after second strobe of len=10 play -> no third strobe, play_done next cycle, cmd_ready=1 after.
REQ-038 reset low mid-play -> all outputs at reset values immediately; with NOTE_SEQ_LOOP_EN, cmd_op=11 runs past 128 strobes until abort.
